rc4_decrypt_fsm: RTL and testbench

RC4 pseudo-random generation (PRGA) and decryption engine. It runs after the key-schedule init and shuffle phases have left S[0..255] in s_memory.
- Reads S, performs the i/j swap per byte, and fetches keystream byte f.
- XORs f with encrypted_message[k] and writes the result into decrypted_message[k].
- It is the consumer/reader side of the S array the key-schedule FSMs write.
- It is sequenced by state_machine_control with the same start/finish level handshake as the init and shuffle FSMs.

---
 rtl/rc4_pkg.sv | 28 ++
 rtl/rc4_decrypt_fsm.sv | 136 +++++++++++++
 tb/tb_rc4_decrypt_fsm.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 decryption engine: FSM state encoding and
// the plaintext character-class check used for early termination.
package rc4_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RD_SI,
      ST_CAP_SI,
      ST_RD_SJ,
      ST_CAP_SJ,
      ST_WR_SI,
      ST_WR_SJ,
      ST_RD_F,
      ST_CAP_F,
      ST_WR_D,
      ST_DONE
   } state_t;

   localparam logic [7:0] CHAR_SPACE = 8'd32;
   localparam logic [7:0] CHAR_A     = 8'd97;
   localparam logic [7:0] CHAR_Z     = 8'd122;

   // Accepted plaintext alphabet: lowercase letters and space.
   function automatic logic is_valid_char(input logic [7:0] c);
      return (c == CHAR_SPACE) || ((c >= CHAR_A) && (c <= CHAR_Z));
   endfunction

endpackage

// File: rtl/rc4_decrypt_fsm.sv
// RC4 PRGA stage: swaps S[i]/S[j] in s_memory, fetches the keystream byte and
// writes encrypted XOR keystream into decrypted_message, one byte per 9 cycles.
module rc4_decrypt_fsm
   import rc4_pkg::*;
#(
   parameter int MSG_LEN  = 32,
   parameter bit CHECK_EN = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       finish,
   output logic       fail,
   output logic [7:0] s_addr,
   output logic [7:0] s_wr_data,
   output logic       s_wren,
   input  logic [7:0] s_q,
   output logic [7:0] m_addr,
   input  logic [7:0] m_q,
   output logic [7:0] d_addr,
   output logic [7:0] d_data,
   output logic       d_wren
);

   localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

   state_t     state;
   state_t     state_next;
   logic [7:0] i;
   logic [7:0] j;
   logic [7:0] k;
   logic [7:0] si;
   logic [7:0] sj;
   logic [7:0] f;
   logic       bad_char;

   assign bad_char = CHECK_EN && !is_valid_char(f);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         i     <= '0;
         j     <= '0;
         k     <= '0;
         si    <= '0;
         sj    <= '0;
         f     <= '0;
         fail  <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  i    <= 8'd1;
                  j    <= '0;
                  k    <= '0;
                  fail <= 1'b0;
               end
            end
            ST_CAP_SI: begin
               si <= s_q;
               j  <= j + s_q;
            end
            ST_CAP_SJ: sj <= s_q;
            ST_CAP_F:  f  <= s_q ^ m_q;
            ST_WR_D: begin
               if (bad_char) begin
                  fail <= 1'b1;
               end else if (k != LAST_K) begin
                  k <= k + 8'd1;
                  i <= i + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs depend only on state and registers; reads in RD_* are captured
   // in the following CAP_* state because the memories have one-cycle latency.
   always_comb begin
      state_next = state;
      finish     = 1'b0;
      s_addr     = '0;
      s_wr_data  = '0;
      s_wren     = 1'b0;
      m_addr     = '0;
      d_addr     = '0;
      d_data     = '0;
      d_wren     = 1'b0;
      case (state)
         ST_IDLE:   if (start) state_next = ST_RD_SI;
         ST_RD_SI: begin
            s_addr     = i;
            state_next = ST_CAP_SI;
         end
         ST_CAP_SI: state_next = ST_RD_SJ;
         ST_RD_SJ: begin
            s_addr     = j;
            state_next = ST_CAP_SJ;
         end
         ST_CAP_SJ: state_next = ST_WR_SI;
         ST_WR_SI: begin
            s_addr     = i;
            s_wr_data  = sj;
            s_wren     = 1'b1;
            state_next = ST_WR_SJ;
         end
         ST_WR_SJ: begin
            s_addr     = j;
            s_wr_data  = si;
            s_wren     = 1'b1;
            state_next = ST_RD_F;
         end
         ST_RD_F: begin
            s_addr     = si + sj;
            m_addr     = k;
            state_next = ST_CAP_F;
         end
         ST_CAP_F: state_next = ST_WR_D;
         ST_WR_D: begin
            d_addr = k;
            d_data = f;
            d_wren = 1'b1;
            if (bad_char || (k == LAST_K)) state_next = ST_DONE;
            else                           state_next = ST_RD_SI;
         end
         ST_DONE: begin
            finish = 1'b1;
            if (!start) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_rc4_decrypt_fsm.sv
// Directed bench for rc4_decrypt_fsm: four parameterisations share one set of
// behavioural memories, selected by sel, with hand-derived expected bytes.
module tb_rc4_decrypt_fsm;

   logic clk = 1'b0;
   logic reset;
   logic [1:0] sel;

   logic [3:0]       start;
   logic [3:0]       fin;
   logic [3:0]       fl;
   logic [3:0]       swe;
   logic [3:0]       dwe;
   logic [3:0][7:0]  sa;
   logic [3:0][7:0]  swd;
   logic [3:0][7:0]  ma;
   logic [3:0][7:0]  da;
   logic [3:0][7:0]  dd;

   logic [7:0] s_addr, s_wr_data, m_addr, d_addr, d_data;
   logic       s_wren, d_wren;
   logic [7:0] s_q, m_q;

   logic [7:0] s_mem  [256];
   logic [7:0] s_init [256];
   logic [7:0] m_init [256];
   logic [7:0] d_mem  [256];
   logic [7:0] exp_ks [256];
   logic       load_mem;
   int         s_writes;
   int         d_writes;

   int errors = 0;
   int checks = 0;
   int cyc;
   int w_s, w_d;

   always #5 clk = ~clk;

   rc4_decrypt_fsm #(.MSG_LEN(3), .CHECK_EN(1'b1)) u0 (
      .clk(clk), .reset(reset), .start(start[0]), .finish(fin[0]), .fail(fl[0]),
      .s_addr(sa[0]), .s_wr_data(swd[0]), .s_wren(swe[0]), .s_q(s_q),
      .m_addr(ma[0]), .m_q(m_q), .d_addr(da[0]), .d_data(dd[0]), .d_wren(dwe[0]));
   rc4_decrypt_fsm #(.MSG_LEN(9), .CHECK_EN(1'b0)) u1 (
      .clk(clk), .reset(reset), .start(start[1]), .finish(fin[1]), .fail(fl[1]),
      .s_addr(sa[1]), .s_wr_data(swd[1]), .s_wren(swe[1]), .s_q(s_q),
      .m_addr(ma[1]), .m_q(m_q), .d_addr(da[1]), .d_data(dd[1]), .d_wren(dwe[1]));
   rc4_decrypt_fsm #(.MSG_LEN(9), .CHECK_EN(1'b1)) u2 (
      .clk(clk), .reset(reset), .start(start[2]), .finish(fin[2]), .fail(fl[2]),
      .s_addr(sa[2]), .s_wr_data(swd[2]), .s_wren(swe[2]), .s_q(s_q),
      .m_addr(ma[2]), .m_q(m_q), .d_addr(da[2]), .d_data(dd[2]), .d_wren(dwe[2]));
   rc4_decrypt_fsm #(.MSG_LEN(256), .CHECK_EN(1'b0)) u3 (
      .clk(clk), .reset(reset), .start(start[3]), .finish(fin[3]), .fail(fl[3]),
      .s_addr(sa[3]), .s_wr_data(swd[3]), .s_wren(swe[3]), .s_q(s_q),
      .m_addr(ma[3]), .m_q(m_q), .d_addr(da[3]), .d_data(dd[3]), .d_wren(dwe[3]));

   always_comb begin
      s_addr    = sa[sel];
      s_wr_data = swd[sel];
      s_wren    = swe[sel];
      m_addr    = ma[sel];
      d_addr    = da[sel];
      d_data    = dd[sel];
      d_wren    = dwe[sel];
   end

   // Synchronous one-cycle-read memories; load_mem reloads S and clears the
   // output buffer to 0xEE so untouched bytes are recognisable.
   always @(posedge clk) begin
      if (load_mem) begin
         for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
      end else if (s_wren) begin
         s_mem[s_addr] <= s_wr_data;
      end
      s_q <= s_mem[s_addr];
      m_q <= m_init[m_addr];
      if (load_mem) begin
         for (int x = 0; x < 256; x++) d_mem[x] <= 8'hEE;
      end else if (d_wren) begin
         d_mem[d_addr] <= d_data;
      end
      if (s_wren) s_writes <= s_writes + 1;
      if (d_wren) d_writes <= d_writes + 1;
   end

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_identity();
      for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
   endtask

   task automatic set_ksa_key();
      logic [7:0] key [3];
      logic [7:0] jj, t;
      key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
      set_identity();
      jj = 8'd0;
      for (int x = 0; x < 256; x++) begin
         jj = jj + s_init[x] + key[x % 3];
         t = s_init[x]; s_init[x] = s_init[jj]; s_init[jj] = t;
      end
   endtask

   task automatic apply_stimulus_load();
      @(negedge clk); load_mem = 1'b1;
      @(negedge clk); load_mem = 1'b0;
   endtask

   // Raises start and counts edges from the one that samples it until finish.
   task automatic run_engine(input int idx, input int budget, output int cycles);
      cycles = 0;
      @(negedge clk); start[idx] = 1'b1;
      do begin
         @(posedge clk); cycles++; #1;
      end while (!fin[idx] && cycles < budget);
      checks++;
      assert (fin[idx] === 1'b1) else begin
         errors++;
         $error("[TB] FAIL finish_timeout observed=%0b expected=1", fin[idx]);
      end
   endtask

   task automatic drop_start(input int idx, input string tag);
      @(negedge clk); start[idx] = 1'b0;
      @(posedge clk); #1;
      check8(tag, {7'd0, fin[idx]}, 8'd0);
   endtask

   initial begin
      logic [7:0] plain [9];
      logic [7:0] enc   [9];
      logic [7:0] ms [256];
      logic [7:0] mi, mj, t;
      plain = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
      enc   = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

      reset = 1'b1; start = '0; sel = 2'd0; load_mem = 1'b0;
      s_writes = 0; d_writes = 0;
      for (int x = 0; x < 256; x++) m_init[x] = 8'h00;
      set_identity();
      repeat (3) @(posedge clk);
      #1;
      check8("rst_finish", {7'd0, fin[0]}, 8'd0);
      check8("rst_fail", {7'd0, fl[0]}, 8'd0);
      check8("rst_s_addr", sa[0], 8'd0);
      check8("rst_wrens", {6'd0, swe[0], dwe[0]}, 8'd0);
      check8("rst_d_data", dd[0], 8'd0);
      @(negedge clk); reset = 1'b0;

      $display("[TB] test 1: identity S, 3 bytes");
      m_init[0] = 8'h63; m_init[1] = 8'h67; m_init[2] = 8'h64;
      apply_stimulus_load();
      run_engine(0, 100, cyc);
      check_int("t1_cycles", cyc, 28);
      check8("t1_fail", {7'd0, fl[0]}, 8'd0);
      check8("t1_d0", d_mem[0], 8'h61);
      check8("t1_d1", d_mem[1], 8'h62);
      check8("t1_d2", d_mem[2], 8'h63);
      check8("t1_s2", s_mem[2], 8'h03);
      check8("t1_s3", s_mem[3], 8'h05);
      check8("t1_s5", s_mem[5], 8'h02);

      $display("[TB] test 4: start held after finish");
      w_s = s_writes; w_d = d_writes;
      repeat (20) @(posedge clk);
      #1;
      check8("t4_hold_finish", {7'd0, fin[0]}, 8'd1);
      check_int("t4_no_s_writes", s_writes, w_s);
      check_int("t4_no_d_writes", d_writes, w_d);
      drop_start(0, "t4_finish_drop");
      apply_stimulus_load();
      run_engine(0, 100, cyc);
      check_int("t4_rerun_cycles", cyc, 28);
      check8("t4_rerun_d0", d_mem[0], 8'h61);
      check8("t4_rerun_d2", d_mem[2], 8'h63);
      drop_start(0, "t4_finish_drop2");

      $display("[TB] test 2: KSA key 'Key', no check");
      sel = 2'd1;
      set_ksa_key();
      for (int x = 0; x < 9; x++) m_init[x] = enc[x];
      apply_stimulus_load();
      run_engine(1, 200, cyc);
      check_int("t2_cycles", cyc, 82);
      check8("t2_fail", {7'd0, fl[1]}, 8'd0);
      for (int x = 0; x < 9; x++) check8($sformatf("t2_d%0d", x), d_mem[x], plain[x]);
      drop_start(1, "t2_finish_drop");

      $display("[TB] test 3: KSA key 'Key', check enabled");
      sel = 2'd2;
      apply_stimulus_load();
      run_engine(2, 200, cyc);
      check_int("t3_cycles", cyc, 10);
      check8("t3_fail", {7'd0, fl[2]}, 8'd1);
      check8("t3_d0", d_mem[0], 8'h50);
      for (int x = 1; x < 9; x++) check8($sformatf("t3_untouched%0d", x), d_mem[x], 8'hEE);
      drop_start(2, "t3_finish_drop");

      $display("[TB] test 5: reset during second byte swap");
      sel = 2'd0;
      set_identity();
      m_init[0] = 8'h63; m_init[1] = 8'h67; m_init[2] = 8'h64;
      apply_stimulus_load();
      @(negedge clk); start[0] = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk); cyc++;
      end while (!(swe[0] && sa[0] == 8'd2) && cyc < 100);
      check_int("t5_reach_wr_si", (swe[0] && sa[0] == 8'd2) ? 1 : 0, 1);
      reset = 1'b1; start[0] = 1'b0;
      @(posedge clk); #1;
      check8("t5_rst_wrens", {6'd0, swe[0], dwe[0]}, 8'd0);
      check8("t5_rst_finish", {7'd0, fin[0]}, 8'd0);
      check8("t5_rst_s_addr", sa[0], 8'd0);
      @(negedge clk); reset = 1'b0;
      apply_stimulus_load();
      run_engine(0, 100, cyc);
      check_int("t5_rerun_cycles", cyc, 28);
      check8("t5_d0", d_mem[0], 8'h61);
      check8("t5_d1", d_mem[1], 8'h62);
      check8("t5_d2", d_mem[2], 8'h63);
      drop_start(0, "t5_finish_drop");

      $display("[TB] test 6: identity S, 256 bytes, zero ciphertext");
      sel = 2'd3;
      for (int x = 0; x < 256; x++) begin
         m_init[x] = 8'h00;
         ms[x] = 8'(x);
      end
      mi = 8'd0; mj = 8'd0;
      for (int n = 0; n < 256; n++) begin
         mi = mi + 8'd1;
         mj = mj + ms[mi];
         t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
         exp_ks[n] = ms[8'(ms[mi] + ms[mj])];
      end
      set_identity();
      apply_stimulus_load();
      run_engine(3, 3000, cyc);
      check_int("t6_cycles", cyc, 2305);
      for (int x = 0; x < 256; x++) check8($sformatf("t6_d%0d", x), d_mem[x], exp_ks[x]);
      drop_start(3, "t6_finish_drop");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
